regbank_ctrl: RTL and testbench

Write-port controller for the register bank. The bank has a single write port (i_write/i_addr/i_value) and no usable power-on initial value.
- Zero-fill sweep: after reset, and on demand, writes zero to every address.
- Round-robin arbiter: shares the write port among NUM_REQ requesters using valid/ready handshakes.
- Output: a registered write command that drives the bank's write inputs directly.

---
 rtl/regbank_ctrl_pkg.sv | 4 +
 rtl/regbank_ctrl_if.sv | 24 ++
 rtl/regbank_ctrl_rr_arbiter.sv | 23 ++
 rtl/regbank_ctrl.sv | 66 ++++++
 tb/tb_regbank_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/regbank_ctrl_pkg.sv
// regbank_pkg: shared types for the register-bank write-port controller
package regbank_pkg;
    typedef enum logic {CLEAR, ARB} state_t;
endpackage

// File: rtl/regbank_ctrl_if.sv
// regbank_ctrl_if: requester handshakes, clear control and bank write command
interface regbank_ctrl_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic                  i_clear;
    logic                  o_busy;
    logic [NUM_REQ-1:0]    i_req_valid;
    logic [ADDR_WIDTH-1:0] i_req_addr [NUM_REQ];
    logic [WORD_WIDTH-1:0] i_req_value [NUM_REQ];
    logic [NUM_REQ-1:0]    o_req_ready;
    logic                  o_write;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [WORD_WIDTH-1:0] o_value;
    modport master (
        output i_clear, i_req_valid, i_req_addr, i_req_value,
        input  o_busy, o_req_ready, o_write, o_addr, o_value
    );
    modport slave (
        input  i_clear, i_req_valid, i_req_addr, i_req_value,
        output o_busy, o_req_ready, o_write, o_addr, o_value
    );
endinterface

// File: rtl/regbank_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or after ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);
    // scan from the farthest offset down so the nearest request wins last
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N]) begin
                idx = PW'((int'(ptr) + i) % N);
                any = 1'b1;
            end
        grant = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/regbank_ctrl.sv
// regbank_ctrl: zero-fill sweep plus round-robin sharing of the bank write port
module regbank_ctrl
    import regbank_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 32,
    parameter int SIZE       = 1 << ADDR_WIDTH,
    parameter int NUM_REQ    = 4
) (
    input logic            i_clk,
    input logic            i_rst,
    regbank_ctrl_if.slave  bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    state_t                state, state_n;
    logic [ADDR_WIDTH:0]   cnt;
    logic [PW-1:0]         ptr, idx;
    logic [NUM_REQ-1:0]    grant;
    logic                  any, last, hs;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] value_q;
    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .req   (bus.i_req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );
    always_comb begin
        last            = cnt == (ADDR_WIDTH + 1)'(SIZE - 1);
        bus.o_req_ready = (state == ARB && !bus.i_clear && any) ? grant : '0;
        hs              = |bus.o_req_ready;
        state_n         = state == CLEAR ? ((last && !bus.i_clear) ? ARB : CLEAR)
                                         : (bus.i_clear ? CLEAR : ARB);
        bus.o_busy      = state == CLEAR;
        bus.o_write     = write_q;
        bus.o_addr      = addr_q;
        bus.o_value     = value_q;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= CLEAR;
            cnt     <= '0;
            ptr     <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            value_q <= '0;
        end else begin
            state <= state_n;
            if (state == CLEAR) begin
                write_q <= 1'b1;
                addr_q  <= cnt[ADDR_WIDTH-1:0];
                value_q <= '0;
                cnt     <= (bus.i_clear || last) ? '0 : cnt + 1'b1;
            end else begin
                write_q <= hs;
                if (hs) begin
                    addr_q  <= bus.i_req_addr[idx];
                    value_q <= bus.i_req_value[idx];
                    ptr     <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_regbank_ctrl.sv
// tb_regbank_ctrl: directed checks of sweep, arbitration, clear and reset with a bank model
module tb_regbank_ctrl;
    localparam int AW = 3;
    localparam int WW = 32;
    localparam int NR = 3;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [WW-1:0] bank [8];
    regbank_ctrl_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .NUM_REQ(NR)) bus ();
    regbank_ctrl #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .SIZE(8), .NUM_REQ(NR)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) if (bus.o_write) bank[bus.o_addr] <= bus.o_value;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask
    task automatic chk_sweep(input int s, input logic busy_exp);
        chk($sformatf("sweep_write_%0d", s), 64'(bus.o_write), 64'(1));
        chk($sformatf("sweep_addr_%0d", s), 64'(bus.o_addr), 64'(s));
        chk($sformatf("sweep_value_%0d", s), 64'(bus.o_value), 64'(0));
        chk($sformatf("sweep_busy_%0d", s), 64'(bus.o_busy), 64'(busy_exp));
    endtask
    initial begin
        bus.i_clear = 1'b0;
        bus.i_req_valid = '0;
        for (int i = 0; i < NR; i++) begin
            bus.i_req_addr[i] = '0;
            bus.i_req_value[i] = '0;
        end
        cyc();
        chk("rst_write", 64'(bus.o_write), 64'(0));
        chk("rst_addr", 64'(bus.o_addr), 64'(0));
        chk("rst_busy", 64'(bus.o_busy), 64'(1));
        i_rst = 1'b0;
        // power-up sweep
        for (int s = 0; s < 8; s++) begin
            cyc();
            chk_sweep(s, s < 7);
            chk($sformatf("sweep_ready_%0d", s), 64'(bus.o_req_ready), 64'(0));
        end
        cyc();
        chk("idle_write", 64'(bus.o_write), 64'(0));
        chk("idle_busy", 64'(bus.o_busy), 64'(0));
        for (int a = 0; a < 8; a++) chk($sformatf("bank_zero_%0d", a), 64'(bank[a]), 64'(0));
        // single request
        bus.i_req_valid = 3'b010;
        bus.i_req_addr[1] = 3'd5;
        bus.i_req_value[1] = 32'hDEADBEEF;
        #1;
        chk("single_ready", 64'(bus.o_req_ready), 64'(3'b010));
        cyc();
        bus.i_req_valid = '0;
        #1;
        chk("single_write", 64'(bus.o_write), 64'(1));
        chk("single_addr", 64'(bus.o_addr), 64'(5));
        chk("single_value", 64'(bus.o_value), 64'(32'hDEADBEEF));
        cyc();
        chk("single_bank", 64'(bank[5]), 64'(32'hDEADBEEF));
        chk("single_nowrite", 64'(bus.o_write), 64'(0));
        chk("hold_addr", 64'(bus.o_addr), 64'(5));
        // ptr is 2 now: req0 and req2 valid must grant req2
        for (int i = 0; i < NR; i++) begin
            bus.i_req_addr[i] = 3'(i);
            bus.i_req_value[i] = 32'h100 + 32'(i);
        end
        bus.i_req_valid = 3'b101;
        #1;
        chk("ptr2_ready", 64'(bus.o_req_ready), 64'(3'b100));
        cyc();
        bus.i_req_valid = 3'b111;
        #1;
        chk("ptr2_addr", 64'(bus.o_addr), 64'(2));
        chk("ptr2_value", 64'(bus.o_value), 64'(32'h102));
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rr_ready_%0d", k), 64'(bus.o_req_ready), 64'(1 << (k % 3)));
            cyc();
            if (k == 5) bus.i_req_valid = '0;
            #1;
            chk($sformatf("rr_write_%0d", k), 64'(bus.o_write), 64'(1));
            chk($sformatf("rr_addr_%0d", k), 64'(bus.o_addr), 64'(k % 3));
            chk($sformatf("rr_value_%0d", k), 64'(bus.o_value), 64'(32'h100 + 32'(k % 3)));
        end
        cyc();
        chk("rr_idle_write", 64'(bus.o_write), 64'(0));
        chk("rr_idle_addr", 64'(bus.o_addr), 64'(2));
        // request arriving during a sweep
        bus.i_clear = 1'b1;
        #1;
        chk("clr_ready_none", 64'(bus.o_req_ready), 64'(0));
        cyc();
        bus.i_clear = 1'b0;
        #1;
        chk("clr_busy", 64'(bus.o_busy), 64'(1));
        chk("clr_first_nowrite", 64'(bus.o_write), 64'(0));
        bus.i_req_addr[0] = 3'd6;
        bus.i_req_value[0] = 32'hCAFE0006;
        for (int s = 0; s < 8; s++) begin
            cyc();
            if (s == 1) bus.i_req_valid = 3'b001;
            #1;
            chk_sweep(s, s < 7);
            chk($sformatf("sweepreq_ready_%0d", s), 64'(bus.o_req_ready), 64'(s == 7 ? 3'b001 : 3'b000));
        end
        cyc();
        bus.i_req_valid = '0;
        #1;
        chk("sweepreq_write", 64'(bus.o_write), 64'(1));
        chk("sweepreq_addr", 64'(bus.o_addr), 64'(6));
        cyc();
        chk("sweepreq_bank6", 64'(bank[6]), 64'(32'hCAFE0006));
        chk("sweepreq_bank7", 64'(bank[7]), 64'(0));
        // clear beats a pending request, then restart mid-sweep
        bus.i_req_valid = 3'b100;
        bus.i_clear = 1'b1;
        #1;
        chk("clrreq_ready", 64'(bus.o_req_ready), 64'(0));
        cyc();
        bus.i_clear = 1'b0;
        bus.i_req_valid = '0;
        #1;
        chk("clrreq_nowrite", 64'(bus.o_write), 64'(0));
        for (int s = 0; s < 5; s++) begin
            cyc();
            if (s == 3) bus.i_clear = 1'b1;
            if (s == 4) bus.i_clear = 1'b0;
            #1;
            chk_sweep(s, 1'b1);
        end
        for (int s = 0; s < 8; s++) begin
            cyc();
            chk_sweep(s, s < 7);
        end
        cyc();
        chk("restart_done", 64'(bus.o_write), 64'(0));
        // reset in the middle of a sweep
        bus.i_clear = 1'b1;
        cyc();
        bus.i_clear = 1'b0;
        for (int s = 0; s < 4; s++) begin
            cyc();
            chk_sweep(s, 1'b1);
        end
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        #1;
        chk("midrst_write", 64'(bus.o_write), 64'(0));
        chk("midrst_addr", 64'(bus.o_addr), 64'(0));
        chk("midrst_busy", 64'(bus.o_busy), 64'(1));
        for (int s = 0; s < 8; s++) begin
            cyc();
            chk_sweep(s, s < 7);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
